fetch_unit: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs, and drops wrong-path responses on a branch redirect.
- Presents one {pc, instruction} pair per cycle to IF/ID; inserts a NOP bubble when nothing is buffered.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the buffered fetch entry type for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head data is presented combinationally from the read pointer.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = store[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) store[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order memory requests under a credit limit,
// buffers {pc, instr} pairs for IF/ID and drops wrong-path responses after a redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        if_valid
);

   localparam int          CW           = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] pcq_count;
   logic          buf_full;
   logic          buf_empty;
   logic          pcq_full;
   logic          pcq_empty;
   logic [31:0]   pcq_head;
   fetch_entry_t  buf_head;
   fetch_entry_t  buf_wdata;
   logic          issue;
   logic          resp_drop;
   logic          buf_push;
   logic          buf_pop;

   // Outstanding counts every request still in flight, including those marked for dropping,
   // so the in-flight queue and the buffer can never overflow.
   assign imem_req  = !reset && !branch_taken &&
                      (({1'b0, outstanding} + {1'b0, buf_count}) < CREDIT_LIMIT);
   assign imem_addr = fetch_pc;
   assign issue     = imem_req & imem_ready;
   assign resp_drop = imem_rvalid & ((drop_cnt != '0) | branch_taken);
   assign buf_push  = imem_rvalid & ~resp_drop;
   assign buf_pop   = ~buf_empty & id_write & ~branch_taken;
   assign buf_wdata = '{pc: pcq_head, instr: imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fetch_buf (
      .clk   (clk),
      .reset (reset),
      .push  (buf_push),
      .pop   (buf_pop),
      .flush (branch_taken),
      .wdata (buf_wdata),
      .head  (buf_head),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_queue (
      .clk   (clk),
      .reset (reset),
      .push  (issue),
      .pop   (imem_rvalid),
      .flush (1'b0),
      .wdata (fetch_pc),
      .head  (pcq_head),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (pcq_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         if (branch_taken)
            fetch_pc <= branch_target & ~32'h3;
         else if (issue)
            fetch_pc <= fetch_pc + 32'd4;
         outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
         if (branch_taken)
            drop_cnt <= outstanding - CW'(imem_rvalid);
         else if (imem_rvalid && drop_cnt != '0)
            drop_cnt <= drop_cnt - CW'(1);
      end
   end

   assign if_valid       = ~buf_empty;
   assign if_pc          = buf_empty ? 32'd0 : buf_head.pc;
   assign if_instruction = buf_empty ? NOP_INSTR : buf_head.instr;

   a_rsp_has_req: assert property (@(posedge clk) disable iff (reset)
      imem_rvalid |-> !pcq_empty);
   a_credit_track: assert property (@(posedge clk) disable iff (reset)
      outstanding == pcq_count);
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(buf_push && buf_full) && !(issue && pcq_full));

endmodule
